// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit opcodes and the bitwise evaluation function.
// Used by logic_unit_core and by logic_unit_pipe.
package alu_pkg;

   localparam int OP_W    = 3;
   // Native width of logic_eval; wider datapaths are evaluated in slices.
   localparam int LOGIC_W = 64;

   typedef enum logic [OP_W-1:0] {
      OP_NAND  = 3'd0,
      OP_AND   = 3'd1,
      OP_OR    = 3'd2,
      OP_NOR   = 3'd3,
      OP_XOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_NOT_A = 3'd6,
      OP_PASS_A = 3'd7
   } op_e;

   function automatic logic [LOGIC_W-1:0] logic_eval(input op_e op,
                                                     input logic [LOGIC_W-1:0] a,
                                                     input logic [LOGIC_W-1:0] b);
      logic [LOGIC_W-1:0] r;
      case (op)
         OP_NAND:  r = ~(a & b);
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_NOR:   r = ~(a | b);
         OP_XOR:   r = a ^ b;
         OP_XNOR:  r = ~(a ^ b);
         OP_NOT_A: r = ~a;
         default:  r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit bitwise evaluator built on alu_pkg::logic_eval.
// Any WIDTH >= 1 is supported by evaluating the operands in LOGIC_W-bit slices.
module logic_unit_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   localparam int N_CHUNK = (WIDTH + LOGIC_W - 1) / LOGIC_W;

   // Every function is bitwise, so slicing the operands changes nothing.
   for (genvar c = 0; c < N_CHUNK; c++) begin : g_chunk
      localparam int LO = c * LOGIC_W;
      localparam int CW = ((WIDTH - LO) < LOGIC_W) ? (WIDTH - LO) : LOGIC_W;

      assign y_o[LO +: CW] = CW'(logic_eval(op_e'(op_i),
                                            LOGIC_W'(a_i[LO +: CW]),
                                            LOGIC_W'(b_i[LO +: CW])));
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control and chain mode.
// Define LOGIC_UNIT_FLAGS_EN to add the registered zero/parity result flags.
module logic_unit_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic             chain,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
   output logic             zero,
   output logic             parity,
`endif
   output logic [WIDTH-1:0] y
);

   logic             s1_v_q, s1_v_d;
   logic [OP_W-1:0]  s1_op_q;
   logic             s1_chain_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;

   logic             s2_v_q, s2_v_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] chain_q, chain_d;

   logic             s2_can_load;
   logic             s1_adv;
   logic             in_acc;
   logic [WIDTH-1:0] eff_b;
   logic [WIDTH-1:0] core_y;

   assign s2_can_load = !s2_v_q || out_ready;
   assign s1_adv      = s1_v_q && s2_can_load;
   assign in_ready    = !s1_v_q || s2_can_load;
   assign in_acc      = in_valid && in_ready;

   // chain_q always holds the result of the op that entered S2 just before S1's op.
   assign eff_b = s1_chain_q ? chain_q : s1_b_q;

   logic_unit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op_i (s1_op_q),
      .a_i  (s1_a_q),
      .b_i  (eff_b),
      .y_o  (core_y)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      s1_v_d  = s1_v_q;
      s2_v_d  = s2_v_q;
      y_d     = y_q;
      chain_d = chain_q;

      if (in_acc) begin
         s1_v_d = 1'b1;
      end else if (s1_adv) begin
         s1_v_d = 1'b0;
      end

      if (s2_can_load) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            y_d     = core_y;
            chain_d = core_y;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q  <= 1'b0;
         s2_v_q  <= 1'b0;
         y_q     <= '0;
         chain_q <= '0;
      end else begin
         s1_v_q  <= s1_v_d;
         s2_v_q  <= s2_v_d;
         y_q     <= y_d;
         chain_q <= chain_d;
      end
   end

   // NOTE: S1 payload is only ever read while s1_v_q is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (in_acc) begin
         s1_op_q    <= op;
         s1_chain_q <= chain;
         s1_a_q     <= a;
         s1_b_q     <= b;
      end
   end

   assign out_valid = s2_v_q;
   assign y         = y_q;

`ifdef LOGIC_UNIT_FLAGS_EN
   logic zero_q, parity_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q   <= 1'b1;
         parity_q <= 1'b0;
      end else if (s1_adv) begin
         zero_q   <= ~|core_y;
         parity_q <= ^core_y;
      end
   end

   assign zero   = zero_q;
   assign parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed steps plus random traffic
// scored against a queue-based reference model.
module tb_logic_unit_pipe;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid, in_ready, chain, out_valid, out_ready;
   logic [2:0]   op;
   logic [W-1:0] a, b, y;

   int n_checks = 0;
   int n_err    = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_chain;
   logic [W-1:0] hold_y;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .chain     (chain),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef LOGIC_UNIT_FLAGS_EN
      .zero      (),
      .parity    (),
`endif
      .y         (y)
   );

`ifdef LOGIC_UNIT_FLAGS_EN
   logic        f_in_valid, f_in_ready, f_out_valid, f_zero, f_parity;
   logic [2:0]  f_op;
   logic [15:0] f_a, f_b, f_y;

   logic_unit_pipe #(.WIDTH(16)) dut_f (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (f_in_valid),
      .in_ready  (f_in_ready),
      .op        (f_op),
      .chain     (1'b0),
      .a         (f_a),
      .b         (f_b),
      .out_valid (f_out_valid),
      .out_ready (1'b1),
      .zero      (f_zero),
      .parity    (f_parity),
      .y         (f_y)
   );
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the eight functions written straight from their truth definitions.
   function automatic logic [W-1:0] ref_fn(input int o, input logic [W-1:0] x, input logic [W-1:0] z);
      case (o)
         0: return ~(x & z);
         1: return x & z;
         2: return x | z;
         3: return ~(x | z);
         4: return x ^ z;
         5: return ~(x ^ z);
         6: return ~x;
         default: return x;
      endcase
   endfunction

   // One clock: score handshakes seen before the edge, then step to 1 ns after it.
   task automatic tick();
      logic [W-1:0] e;
      @(negedge clk);
      if (in_valid && in_ready) begin
         e = ref_fn(int'(op), a, chain ? m_chain : b);
         m_chain = e;
         exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_out", 1, 0);
         else check("sb_y", y, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue_wait(input string tag, input int o, input logic ch,
                             input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [W-1:0] expv);
      op = 3'(o); chain = ch; a = av; b = bv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_early"}, out_valid, 0);
      tick();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_y"}, y, expv);
      tick();
   endtask

   task automatic rand_op();
      op    = 3'($urandom_range(7));
      chain = 1'($urandom_range(1));
      a     = W'($urandom);
      b     = W'($urandom);
   endtask

   logic [W-1:0] sweep_exp [8];

   initial begin
      in_valid = 0; op = 0; chain = 0; a = 0; b = 0; out_ready = 1;
      m_chain = '0;
`ifdef LOGIC_UNIT_FLAGS_EN
      f_in_valid = 0; f_op = 0; f_a = 0; f_b = 0;
`endif
      sweep_exp[0] = 4'b0111; sweep_exp[1] = 4'b1000; sweep_exp[2] = 4'b1110;
      sweep_exp[3] = 4'b0001; sweep_exp[4] = 4'b0110; sweep_exp[5] = 4'b1001;
      sweep_exp[6] = 4'b0011; sweep_exp[7] = 4'b1100;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
`ifdef LOGIC_UNIT_FLAGS_EN
      check("rst_zero", f_zero, 1);
      check("rst_parity", f_parity, 0);
`endif
      rst_n = 1'b1;
      tick();

      // All eight functions on a=1100, b=1010
      for (int i = 0; i < 8; i++) begin
         issue_wait($sformatf("op%0d", i), i, 1'b0, 4'b1100, 4'b1010, sweep_exp[i]);
      end

      // Chain sequence
      issue_wait("chain_or",   2, 1'b0, 4'b0001, 4'b0010, 4'b0011);
      issue_wait("chain_xor",  4, 1'b1, 4'b0101, 4'b1111, 4'b0110);
      issue_wait("chain_nand", 0, 1'b1, 4'b1111, 4'b0000, 4'b1001);
      check("sb_empty_a", exp_q.size(), 0);

      // Backpressure: two accepted, third refused, y frozen
      out_ready = 1'b0;
      in_valid = 1'b1;
      rand_op(); tick();
      rand_op(); tick();
      rand_op(); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      hold_y = y;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_y_hold", y, hold_y);
         check("bp_in_ready_hold", in_ready, 0);
      end
      out_ready = 1'b1; #1;
      check("bp_release_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         check("bp_drain_valid", out_valid, 1);
         tick();
         in_valid = 1'b0;
      end
      check("bp_drain_done", out_valid, 0);
      check("sb_empty_b", exp_q.size(), 0);

      // Throughput: 16 back-to-back random operations
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rand_op();
         tick();
         if (i >= 1) check("tp_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      tick();
      check("tp_valid_last", out_valid, 1);
      tick();
      check("tp_done", out_valid, 0);
      check("sb_empty_c", exp_q.size(), 0);

      // Reset with both stages full
      out_ready = 1'b0;
      op = 3'd7; chain = 1'b0; a = 4'b1010; b = 4'b0000; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      check("pre_rst_full", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      exp_q.delete();
      m_chain = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      issue_wait("rst_chain", 2, 1'b1, 4'b0000, 4'b1111, 4'b0000);
      check("sb_empty_d", exp_q.size(), 0);

`ifdef LOGIC_UNIT_FLAGS_EN
      f_op = 3'd0; f_a = 16'hFFFF; f_b = 16'hFFFF; f_in_valid = 1'b1;
      @(posedge clk); #1;
      f_in_valid = 1'b0;
      @(posedge clk); #1;
      check("flg_nand_valid", f_out_valid, 1);
      check("flg_nand_y", f_y, 16'h0000);
      check("flg_nand_zero", f_zero, 1);
      check("flg_nand_parity", f_parity, 0);
      f_op = 3'd7; f_a = 16'h0007; f_b = 16'h0000; f_in_valid = 1'b1;
      @(posedge clk); #1;
      f_in_valid = 1'b0;
      @(posedge clk); #1;
      check("flg_pass_y", f_y, 16'h0007);
      check("flg_pass_zero", f_zero, 0);
      check("flg_pass_parity", f_parity, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
